// File: rtl/user_wb_mailbox.sv
// user_wb_mailbox: Wishbone-slave mailbox FIFO for the user project area.
// Four word registers decoded from adr[3:2]: DATA (push/pop), STATUS, CTRL, CLEAR.
// Optional build macro MAILBOX_IRQ_EN enables the CTRL register and the
// count-threshold interrupt; without it irq is tied low and CTRL reads 0.
module user_wb_mailbox #(
    parameter int DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] L_REG_DATA   = 2'd0;
    localparam logic [1:0] L_REG_STATUS = 2'd1;
    localparam logic [1:0] L_REG_CTRL   = 2'd2;
    localparam logic [1:0] L_REG_CLEAR  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_access;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_udf;
    logic [31:0]   r_dat;

    logic [1:0]    w_reg;
    logic          w_wr_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    logic          w_empty;
    logic          w_full;
    logic [4:0]    w_count5;
    logic [31:0]   w_status;
    logic [31:0]   w_ctrl_rd;
    logic [31:0]   w_rd_data;
    logic          w_unused_ok;

    assign w_reg       = wbs_adr_i[3:2];
    assign w_unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == L_FULL_CNT);
    assign w_count5    = 5'(r_count);

    // A write with no byte lane selected is acknowledged but changes nothing.
    assign w_wr_valid  = w_access & wbs_we_i & (|wbs_sel_i);
    assign w_push      = w_wr_valid & (w_reg == L_REG_DATA);
    assign w_clear     = w_wr_valid & (w_reg == L_REG_CLEAR);
    assign w_pop       = w_access & ~wbs_we_i & (w_reg == L_REG_DATA);

    assign w_status    = {14'd0, r_udf, r_ovf, 6'd0, w_full, w_empty, 3'd0, w_count5};

    assign wbs_ack_o   = (r_state == ST_ACK);
    assign wbs_dat_o   = r_dat;

    // Handshake state register: ACK lasts exactly one cycle after an accepted access.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept a new access only from IDLE, then always fall back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read mux; an empty DATA read returns zero rather than a stale word.
    always_comb begin
        w_rd_data = 32'd0;
        case (w_reg)
            L_REG_DATA:   w_rd_data = w_empty ? 32'd0 : r_mem[r_rptr];
            L_REG_STATUS: w_rd_data = w_status;
            L_REG_CTRL:   w_rd_data = w_ctrl_rd;
            L_REG_CLEAR:  w_rd_data = 32'd0;
            default:      w_rd_data = 32'd0;
        endcase
    end

    // Read data is captured with the ack and forced to zero outside the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_dat <= 32'd0;
        end else if (w_access && !wbs_we_i) begin
            r_dat <= w_rd_data;
        end else begin
            r_dat <= 32'd0;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge wb_clk_i) begin
        if (w_push && !w_full) begin
            r_mem[r_wptr] <= wbs_dat_i;
        end
    end

    // FIFO pointers, occupancy and sticky overflow/underflow flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wptr  <= r_wptr + 1'b1;
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_pop) begin
                if (w_empty) begin
                    r_udf <= 1'b1;
                end else begin
                    r_rptr  <= r_rptr + 1'b1;
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_clear && wbs_dat_i[0]) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
            if (w_clear && wbs_dat_i[1]) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic [4:0] r_thresh;
    logic       r_irq_en;
    logic       r_irq;
    logic       w_ctrl_wr;

    assign w_ctrl_wr = w_wr_valid & (w_reg == L_REG_CTRL);
    assign w_ctrl_rd = {23'd0, r_irq_en, 3'd0, r_thresh};
    assign irq       = r_irq;

    // CTRL fields, each updated only when its byte lane is selected.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_thresh <= 5'd1;
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            if (wbs_sel_i[0]) begin
                r_thresh <= wbs_dat_i[4:0];
            end
            if (wbs_sel_i[1]) begin
                r_irq_en <= wbs_dat_i[8];
            end
        end
    end

    // Level interrupt follows the occupancy one cycle later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (w_count5 >= r_thresh);
        end
    end
`else
    assign w_ctrl_rd = 32'd0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_user_wb_mailbox.sv
// Testbench for user_wb_mailbox: queue-based mailbox model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_user_wb_mailbox;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dati;
    logic        ack;
    logic [31:0] dato;
    logic        irqOut;

    user_wb_mailbox #(.DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dati),
        .wbs_ack_o (ack),
        .wbs_dat_o (dato),
        .irq       (irqOut)
    );

    always #5 clk = ~clk;

    logic [31:0] mQueue[$];
    bit          mOvf;
    bit          mUdf;
    int          mThresh;
    bit          mIrqEn;
    logic        expAck;
    logic [31:0] expDat;
    logic        expIrq;
    bit          checkEn;
    int          nVectors;
    int          nMiscompares;

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        s = 32'(mQueue.size());
        if (mQueue.size() == 0)     s = s + 32'h0000_0100;
        if (mQueue.size() == DEPTH) s = s + 32'h0000_0200;
        if (mOvf)                   s = s + 32'h0001_0000;
        if (mUdf)                   s = s + 32'h0002_0000;
        return s;
    endfunction

    function automatic logic [31:0] modelCtrl();
`ifdef MAILBOX_IRQ_EN
        return 32'(mThresh) + (mIrqEn ? 32'h100 : 32'h0);
`else
        return 32'h0;
`endif
    endfunction

    // Mailbox model: one bus transfer per accepted strobe, results shown during the ack cycle.
    always @(posedge clk) begin
        logic        irqNext;
        logic [31:0] rd;
        int          regIdx;
        if (rst) begin
            mQueue.delete();
            mOvf    = 0;
            mUdf    = 0;
            mThresh = 1;
            mIrqEn  = 0;
            expAck  = 1'b0;
            expDat  = 32'h0;
            expIrq  = 1'b0;
        end else begin
`ifdef MAILBOX_IRQ_EN
            irqNext = mIrqEn && (mQueue.size() >= mThresh);
`else
            irqNext = 1'b0;
`endif
            rd = 32'h0;
            if (cyc && stb && !expAck) begin
                regIdx = int'(adr[3:2]);
                if (we) begin
                    if (sel != 4'h0) begin
                        if (regIdx == 0) begin
                            if (mQueue.size() == DEPTH) mOvf = 1;
                            else mQueue.push_back(dati);
                        end else if (regIdx == 2) begin
                            if (sel[0]) mThresh = int'(dati[4:0]);
                            if (sel[1]) mIrqEn = dati[8];
                        end else if (regIdx == 3) begin
                            if (dati[0]) begin
                                mOvf = 0;
                                mUdf = 0;
                            end
                            if (dati[1]) mQueue.delete();
                        end
                    end
                end else begin
                    if (regIdx == 0) begin
                        if (mQueue.size() == 0) mUdf = 1;
                        else rd = mQueue.pop_front();
                    end else if (regIdx == 1) begin
                        rd = modelStatus();
                    end else if (regIdx == 2) begin
                        rd = modelCtrl();
                    end
                end
                expAck = 1'b1;
            end else begin
                expAck = 1'b0;
            end
            expDat = rd;
            expIrq = irqNext;
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            nVectors++;
            if (ack !== expAck || dato !== expDat || irqOut !== expIrq) begin
                nMiscompares++;
                $display("[TB] FAIL cycle_check t=%0t: got ack=%b dat=%h irq=%b, expected ack=%b dat=%h irq=%b",
                         $time, ack, dato, irqOut, expAck, expDat, expIrq);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One bus transfer; returns at the falling edge inside the ack cycle (or one later when held).
    task automatic applyStimulus(input logic wrEn, input logic [1:0] regSel, input logic [31:0] data,
                                 input logic [3:0] byteSel, input logic holdExtra, output logic [31:0] rdData);
        logic [31:0] junk;
        junk = $urandom;
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = wrEn;
        sel  = byteSel;
        dati = data;
        adr  = {junk[31:4], regSel, junk[1:0]};
        @(negedge clk);
        rdData = dato;
        if (holdExtra) @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wrReg(input logic [1:0] regSel, input logic [31:0] data);
        logic [31:0] unusedRd;
        applyStimulus(1'b1, regSel, data, 4'hF, 1'b0, unusedRd);
    endtask

    task automatic rdReg(input logic [1:0] regSel, output logic [31:0] rd);
        applyStimulus(1'b0, regSel, 32'h0, 4'hF, 1'b0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rndDat;
        int          pick;
        logic [1:0]  regSel;
        logic [3:0]  byteSel;
        nVectors     = 0;
        nMiscompares = 0;
        checkEn      = 0;
        rst  = 1'b1;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        sel  = 4'h0;
        adr  = 32'h0;
        dati = 32'h0;
        repeat (2) @(negedge clk);
        checkEn = 1;
        checkOutput("reset_ack", {31'b0, ack}, 32'h0);
        checkOutput("reset_dat", dato, 32'h0);
        checkOutput("reset_irq", {31'b0, irqOut}, 32'h0);
        rst = 1'b0;

        $display("[TB] status after reset");
        rdReg(2'd1, rd);
        checkOutput("status_after_reset", rd, 32'h0000_0100);
        checkOutput("ack_rise", {31'b0, ack}, 32'h1);
        @(negedge clk);
        checkOutput("ack_single_cycle", {31'b0, ack}, 32'h0);
        checkOutput("dat_zero_after_ack", dato, 32'h0);

        $display("[TB] push three, pop three");
        for (int i = 1; i <= 3; i++) wrReg(2'd0, 32'hA5A5_0000 + 32'(i));
        for (int i = 1; i <= 3; i++) begin
            rdReg(2'd0, rd);
            checkOutput("pop_order", rd, 32'hA5A5_0000 + 32'(i));
        end
        rdReg(2'd1, rd);
        checkOutput("status_drained", rd, 32'h0000_0100);

        $display("[TB] write with no byte selects");
        applyStimulus(1'b1, 2'd0, 32'hDEAD_BEEF, 4'h0, 1'b0, rd);
        rdReg(2'd1, rd);
        checkOutput("sel0_no_push", rd, 32'h0000_0100);

        $display("[TB] overflow then underflow");
        for (int i = 0; i < 9; i++) wrReg(2'd0, 32'h1000_0000 + 32'(i));
        rdReg(2'd1, rd);
        checkOutput("status_full_ovf", rd, 32'h0001_0208);
        for (int i = 0; i < 8; i++) begin
            rdReg(2'd0, rd);
            checkOutput("pop_after_full", rd, 32'h1000_0000 + 32'(i));
        end
        rdReg(2'd0, rd);
        checkOutput("pop_empty_zero", rd, 32'h0);
        rdReg(2'd1, rd);
        checkOutput("status_ovf_udf", rd, 32'h0003_0100);
        wrReg(2'd3, 32'h1);
        rdReg(2'd1, rd);
        checkOutput("status_cleared", rd, 32'h0000_0100);

        $display("[TB] flush");
        for (int i = 0; i < 3; i++) wrReg(2'd0, 32'h2000_0000 + 32'(i));
        wrReg(2'd3, 32'h2);
        rdReg(2'd1, rd);
        checkOutput("status_flushed", rd, 32'h0000_0100);
        wrReg(2'd0, 32'h3333_4444);
        rdReg(2'd0, rd);
        checkOutput("pop_after_flush", rd, 32'h3333_4444);

        $display("[TB] control register and interrupt");
        wrReg(2'd2, 32'h0000_0102);
        rdReg(2'd2, rd);
`ifdef MAILBOX_IRQ_EN
        checkOutput("ctrl_readback", rd, 32'h0000_0102);
        wrReg(2'd0, 32'h5);
        wrReg(2'd0, 32'h6);
        checkOutput("irq_low_in_ack", {31'b0, irqOut}, 32'h0);
        @(negedge clk);
        checkOutput("irq_rise", {31'b0, irqOut}, 32'h1);
        rdReg(2'd0, rd);
        checkOutput("irq_hold_in_ack", {31'b0, irqOut}, 32'h1);
        @(negedge clk);
        checkOutput("irq_fall", {31'b0, irqOut}, 32'h0);
        rdReg(2'd0, rd);
`else
        checkOutput("ctrl_reads_zero", rd, 32'h0);
        wrReg(2'd0, 32'h5);
        wrReg(2'd0, 32'h6);
        @(negedge clk);
        checkOutput("irq_tied_low", {31'b0, irqOut}, 32'h0);
        rdReg(2'd0, rd);
        rdReg(2'd0, rd);
`endif

        $display("[TB] reset during a pending write");
        wrReg(2'd0, 32'h7777_0001);
        wrReg(2'd0, 32'h7777_0002);
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        sel  = 4'hF;
        adr  = 32'h0;
        dati = 32'h7777_0003;
        rst  = 1'b1;
        @(negedge clk);
        checkOutput("reset_abort_no_ack", {31'b0, ack}, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        rst = 1'b0;
        rdReg(2'd1, rd);
        checkOutput("reset_abort_count", rd, 32'h0000_0100);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            pick   = int'($urandom_range(0, 5));
            regSel = (pick <= 2) ? 2'd0 : 2'(pick - 2);
            byteSel = 4'($urandom);
            if ($urandom_range(0, 5) == 0) byteSel = 4'h0;
            rndDat = $urandom;
            if (regSel == 2'd3 && $urandom_range(0, 3) != 0) rndDat[1] = 1'b0;
            applyStimulus(1'($urandom), regSel, rndDat, byteSel, ($urandom_range(0, 3) == 0), rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 80) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/user_wb_mailbox.md
USER_WB_MAILBOX -- requirements
Module: user_wb_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words; power of two, 2..16.
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port wbs_cyc_i  input  1  bus cycle, already gated by the wrapper's user-space address decode.
REQ-005 SHALL have ports wbs_stb_i (input, 1, strobe) and wbs_we_i (input, 1, write enable).
REQ-006 SHALL have port wbs_sel_i  input  4  byte selects.
REQ-007 SHALL have port wbs_adr_i  input  32  address; only bits [3:2] are decoded.
REQ-008 SHALL have port wbs_dat_i  input  32  write data.
REQ-009 SHALL have port wbs_ack_o  output  1  transfer acknowledge.
REQ-010 SHALL have port wbs_dat_o  output  32  read data.
REQ-011 SHALL have port irq  output  1  level interrupt, driven onto user_irq[0] by the wrapper.

Function
REQ-012 Register map (adr[3:2]): 0 DATA, 1 STATUS (RO), 2 CTRL, 3 CLEAR (WO, reads 0).
REQ-013 Access = wbs_cyc_i & wbs_stb_i & !wbs_ack_o; wbs_ack_o SHALL rise the cycle after an access and last exactly one cycle.
REQ-014 Register effects (push, pop, CTRL/CLEAR update) SHALL occur on the same edge that raises wbs_ack_o.
REQ-015 wbs_dat_o SHALL be registered, valid only while wbs_ack_o=1, and 0 otherwise.
REQ-016 A write with wbs_sel_i=4'h0 SHALL be acked and have no effect.
REQ-017 A DATA write SHALL push all 32 bits of wbs_dat_i, ignoring sel.
REQ-018 A DATA read SHALL return the head word and pop it.
REQ-019 FIFO: circular buffer, read/write pointers log2(DEPTH) bits wrapping modulo DEPTH; count width log2(DEPTH)+1, range 0..DEPTH.
REQ-020 Push when full: data dropped, count unchanged, STATUS.ovf (sticky) set.
REQ-021 Pop when empty: returns 32'h0, pointers unchanged, STATUS.udf (sticky) set.
REQ-022 STATUS layout: [4:0] count (zero-extended), [8] empty, [9] full, [16] ovf, [17] udf, others 0.
REQ-023 CTRL layout: [4:0] thresh, [8] irq_en; writable only when wbs_sel_i[0]/[1] set for the respective byte.
REQ-024 Write to CLEAR: bit0=1 clears ovf/udf; bit1=1 flushes FIFO (pointers and count to 0); both may be set in one write.
REQ-025 Internal state: IDLE -> ACK on access; ACK -> IDLE unconditionally; a new access is accepted only from IDLE.
REQ-026 Deassertion of wbs_cyc_i while in ACK SHALL NOT cancel the committed effect.

Reset
REQ-027 On wb_rst_i=1 at a clock edge: wbs_ack_o=0, wbs_dat_o=0, irq=0, state IDLE, pointers/count=0, ovf=udf=0, thresh=5'd1, irq_en=0.
REQ-028 Reset asserted mid-transfer SHALL abort it: no ack issued and no push or pop committed; FIFO contents are discarded.

Configuration
REQ-029 Macro MAILBOX_IRQ_EN defined: irq = irq_en & (count >= thresh), registered (one-cycle lag after the count change); thresh=0 asserts irq whenever irq_en=1.
REQ-030 Macro MAILBOX_IRQ_EN undefined: irq tied 0, CTRL[8] and CTRL[4:0] read 0 and ignore writes; all other behaviour unchanged.

Verification
REQ-031 Reset, then read STATUS -> ack one cycle later; data 32'h0000_0100 (empty).
REQ-032 Push 32'hA5A5_0001..0003, then read DATA three times -> same words in order; then STATUS=32'h0000_0100.
REQ-033 Push 9 words with DEPTH=8 -> STATUS=32'h0001_0208; the first 8 words pop back intact; the 9th is lost.
REQ-034 Pop on empty -> data 32'h0, STATUS bit17=1; write CLEAR=1 -> STATUS=32'h0000_0100.
REQ-035 MAILBOX_IRQ_EN defined, CTRL=32'h0000_0102, push 2 words -> irq rises the cycle after the second push's ack; one pop -> irq falls.
REQ-036 Assert wb_rst_i during the ACK-pending cycle of a DATA write -> no ack, count stays 0.
